// File: rtl/mux16_bus_arbiter_pkg.sv
// Shared constants and helpers for the 4-requester round-robin bus arbiter.
package mux16_bus_arbiter_pkg;

  localparam int NREQ = 4;
  localparam int IDXW = 2;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_OWNED = 1'b1;

  function automatic logic [NREQ-1:0] onehot(input logic [IDXW-1:0] idx);
    onehot = '0;
    onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/mux16_bus_arbiter_mux16.sv
// 2:1 word multiplexer; three of these form the 4:1 steering tree.
module mux16 #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  output logic [WIDTH-1:0] y
);

  assign y = sel ? b : a;

endmodule

// File: rtl/mux16_bus_arbiter_rr_pick4.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping mod 4.
module rr_pick4
  import mux16_bus_arbiter_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] ptr,
  output logic            any,
  output logic [IDXW-1:0] idx
);

  logic [IDXW-1:0] cand;

  // NOTE: every variable written in always_comb gets a default first, otherwise a latch is inferred.
  always_comb begin
    any  = |req;
    idx  = ptr;
    cand = ptr;
    // Scan farthest-first so the nearest requester to ptr is the last, winning assignment.
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = ptr + IDXW'(k);
      if (req[cand]) idx = cand;
    end
  end

endmodule

// File: rtl/mux16_bus_arbiter.sv
// Round-robin arbiter steering one of 4 requester words onto a registered shared bus.
// Optional burst limit enabled by defining ARB_BURST_LIMIT_EN.
module mux16_bus_arbiter
  import mux16_bus_arbiter_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int MAX_BURST = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*WIDTH-1:0] din,
  output logic [NREQ-1:0]      gnt,
  output logic [WIDTH-1:0]     bus_out,
  output logic                 bus_valid,
  output logic                 busy
);

  if (MAX_BURST < 1 || MAX_BURST > 255) begin : g_bad_burst
    $error("MAX_BURST must be in 1..255");
  end

  logic [0:0]      state;
  logic [IDXW-1:0] own;
  logic [IDXW-1:0] ptr;
  logic [IDXW-1:0] pick_ptr;
  logic [IDXW-1:0] pick_idx;
  logic            pick_any;
  logic [WIDTH-1:0] lo_word, hi_word, mux_out;
  logic            owner_req;
  logic            burst_done;
  logic            rearb;

  // On release the scan starts just past the outgoing owner, so the re-pick is fair in the same edge.
  assign pick_ptr = (state == ST_OWNED) ? own + IDXW'(1) : ptr;

  rr_pick4 u_pick (
    .req (req),
    .ptr (pick_ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  mux16 #(.WIDTH(WIDTH)) u_mux_lo (
    .a(din[0*WIDTH +: WIDTH]), .b(din[1*WIDTH +: WIDTH]), .sel(own[0]), .y(lo_word)
  );
  mux16 #(.WIDTH(WIDTH)) u_mux_hi (
    .a(din[2*WIDTH +: WIDTH]), .b(din[3*WIDTH +: WIDTH]), .sel(own[0]), .y(hi_word)
  );
  mux16 #(.WIDTH(WIDTH)) u_mux_top (
    .a(lo_word), .b(hi_word), .sel(own[1]), .y(mux_out)
  );

  assign owner_req = req[own];

`ifdef ARB_BURST_LIMIT_EN
  localparam int CNTW = $clog2(MAX_BURST + 1);
  logic [CNTW-1:0] cnt;

  assign burst_done = (cnt == CNTW'(MAX_BURST - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (state == ST_IDLE || rearb) begin
      cnt <= '0;
    end else if (owner_req) begin
      cnt <= cnt + 1'b1;
    end
  end
`else
  assign burst_done = 1'b0;
`endif

  assign rearb = (state == ST_IDLE) || !owner_req || burst_done;
  assign busy  = |gnt;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      own       <= '0;
      ptr       <= '0;
      gnt       <= '0;
      bus_out   <= '0;
      bus_valid <= 1'b0;
    end else begin
      bus_valid <= 1'b0;
      if (state == ST_OWNED && owner_req) begin
        bus_out   <= mux_out;
        bus_valid <= 1'b1;
      end
      if (rearb) begin
        if (state == ST_OWNED) ptr <= pick_ptr;
        if (pick_any) begin
          gnt   <= onehot(pick_idx);
          own   <= pick_idx;
          state <= ST_OWNED;
        end else begin
          gnt   <= '0;
          state <= ST_IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_mux16_bus_arbiter.sv
// Table-driven, scoreboard-checked bench for mux16_bus_arbiter (both ARB_BURST_LIMIT_EN builds).
module tb_mux16_bus_arbiter;

`ifdef ARB_BURST_LIMIT_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [63:0] din;
  logic [3:0]  gnt;
  logic [15:0] bus_out;
  logic        bus_valid;
  logic        busy;

  mux16_bus_arbiter #(.WIDTH(16), .MAX_BURST(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .din       (din),
    .gnt       (gnt),
    .bus_out   (bus_out),
    .bus_valid (bus_valid),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [63:0] din;
    logic [3:0]  gnt;
    logic [15:0] bus;
    logic        vld;
  } vec_t;

  typedef struct {
    logic [3:0]  gnt;
    logic [15:0] bus;
    logic        vld;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Requester i word at vector n is {A+i, 0, n}, so bus_out names both owner and cycle.
  function automatic logic [63:0] pat(input int n);
    logic [63:0] p;
    for (int i = 0; i < 4; i++) p[i*16 +: 16] = {4'(10 + i), 4'h0, 8'(n)};
    return p;
  endfunction

  task automatic add_d(input logic rst, input logic [3:0] rq, input logic [63:0] d,
                       input logic [3:0] g, input logic [15:0] b, input logic v);
    vec_t x;
    x.rst = rst; x.req = rq; x.din = d; x.gnt = g; x.bus = b; x.vld = v;
    vecs.push_back(x);
  endtask

  task automatic add(input logic rst, input logic [3:0] rq,
                     input logic [3:0] g, input logic [15:0] b, input logic v);
    add_d(rst, rq, pat(vecs.size()), g, b, v);
  endtask

  task automatic compare_next(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      n_vec++;
      n_fail++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = sb.pop_front();
      check({tag, ".gnt"},       {12'h0, gnt},       {12'h0, e.gnt});
      check({tag, ".bus_out"},   bus_out,            e.bus);
      check({tag, ".bus_valid"}, {15'h0, bus_valid}, {15'h0, e.vld});
      check({tag, ".busy"},      {15'h0, busy},      {15'h0, |e.gnt});
    end
  endtask

  initial begin
    exp_t e;
    int   lat;

    reset = 1'b1;
    req   = 4'b0000;
    din   = '0;

    // Reset held two cycles with every requester active.
    add(1, 4'b1111, 4'b0000, 16'h0000, 0);                              // v0
    add(1, 4'b1111, 4'b0000, 16'h0000, 0);                              // v1
    // Single requester 2, two-edge latency.
    add_d(0, 4'b0100, {16'h0, 16'h1234, 16'h0, 16'h0}, 4'b0100, 16'h0000, 0); // v2
    add_d(0, 4'b0100, {16'h0, 16'h1234, 16'h0, 16'h0}, 4'b0100, 16'h1234, 1); // v3
    add(0, 4'b0000, 4'b0000, 16'h1234, 0);                              // v4
    // Rotation 0,1,2,3,0 with back-to-back grants.
    add(1, 4'b0000, 4'b0000, 16'h0000, 0);                              // v5
    add(0, 4'b1111, 4'b0001, 16'h0000, 0);                              // v6
    add(0, 4'b1111, 4'b0001, 16'hA007, 1);                              // v7
    add(0, 4'b1110, 4'b0010, 16'hA007, 0);                              // v8
    add(0, 4'b1111, 4'b0010, 16'hB009, 1);                              // v9
    add(0, 4'b1101, 4'b0100, 16'hB009, 0);                              // v10
    add(0, 4'b1111, 4'b0100, 16'hC00B, 1);                              // v11
    add(0, 4'b1011, 4'b1000, 16'hC00B, 0);                              // v12
    add(0, 4'b1111, 4'b1000, 16'hD00D, 1);                              // v13
    add(0, 4'b0111, 4'b0001, 16'hD00D, 0);                              // v14
    add(0, 4'b1111, 4'b0001, 16'hA00F, 1);                              // v15
    // Owner 1 releases with nothing pending; ptr=2 proven by next pick.
    add(0, 4'b0010, 4'b0010, 16'hA00F, 0);                              // v16
    add(0, 4'b0010, 4'b0010, 16'hB011, 1);                              // v17
    add(0, 4'b0000, 4'b0000, 16'hB011, 0);                              // v18
    add(0, 4'b1001, 4'b1000, 16'hB011, 0);                              // v19
    add(0, 4'b1001, 4'b1000, 16'hD014, 1);                              // v20
    add(0, 4'b0000, 4'b0000, 16'hD014, 0);                              // v21
    // Simultaneous requests from ptr=0, and no preemption by requester 0.
    add(0, 4'b1010, 4'b0010, 16'hD014, 0);                              // v22
    add(0, 4'b1010, 4'b0010, 16'hB017, 1);                              // v23
    add(0, 4'b1011, 4'b0010, 16'hB018, 1);                              // v24
    add(0, 4'b1001, 4'b1000, 16'hB018, 0);                              // v25
    add(0, 4'b0000, 4'b0000, 16'hB018, 0);                              // v26
    // Move ptr to 3, then reset mid-burst of owner 2.
    add(0, 4'b0100, 4'b0100, 16'hB018, 0);                              // v27
    add(0, 4'b0100, 4'b0100, 16'hC01C, 1);                              // v28
    add(0, 4'b0000, 4'b0000, 16'hC01C, 0);                              // v29
    add(0, 4'b0100, 4'b0100, 16'hC01C, 0);                              // v30
    add(0, 4'b0100, 4'b0100, 16'hC01F, 1);                              // v31
    add(0, 4'b0100, 4'b0100, 16'hC020, 1);                              // v32
    add(0, 4'b0100, 4'b0100, 16'hC021, 1);                              // v33
    add(1, 4'b0110, 4'b0000, 16'h0000, 0);                              // v34
    add(0, 4'b1110, 4'b0010, 16'h0000, 0);                              // v35
    add(0, 4'b1110, 4'b0010, 16'hB024, 1);                              // v36
    add(0, 4'b0000, 4'b0000, 16'hB024, 0);                              // v37
    // Burst limit: owner 0 held with requester 1 waiting.
    add(0, 4'b0011, 4'b0001, 16'hB024, 0);                              // v38
    add(0, 4'b0011, 4'b0001, 16'hA027, 1);                              // v39
    add(0, 4'b0011, 4'b0001, 16'hA028, 1);                              // v40
    add(0, 4'b0011, 4'b0001, 16'hA029, 1);                              // v41
    add(0, 4'b0011, 4'b0001, 16'hA02A, 1);                              // v42
    add(0, 4'b0011, 4'b0001, 16'hA02B, 1);                              // v43
    add(0, 4'b0011, 4'b0001, 16'hA02C, 1);                              // v44
    add(0, 4'b0011, 4'b0001, 16'hA02D, 1);                              // v45
    add(0, 4'b0011, BURST ? 4'b0010 : 4'b0001, 16'hA02E, 1);            // v46
    add(0, 4'b0011, BURST ? 4'b0010 : 4'b0001, BURST ? 16'hB02F : 16'hA02F, 1); // v47
    add(0, 4'b0001, 4'b0001, BURST ? 16'hB02F : 16'hA030, !BURST);      // v48
    add(1, 4'b0000, 4'b0000, 16'h0000, 0);                              // v49
    // Sole requester re-wins at the burst boundary with no dead cycle.
    add(0, 4'b0001, 4'b0001, 16'h0000, 0);                              // v50
    for (int n = 51; n <= 60; n++)
      add(0, 4'b0001, 4'b0001, {8'hA0, 8'(n)}, 1);                      // v51..v60
    add(1, 4'b0000, 4'b0000, 16'h0000, 0);                              // v61

    foreach (vecs[i]) begin
      @(negedge clk);
      reset = vecs[i].rst;
      req   = vecs[i].req;
      din   = vecs[i].din;
      e.gnt = vecs[i].gnt; e.bus = vecs[i].bus; e.vld = vecs[i].vld;
      sb.push_back(e);
      @(posedge clk);
      #1;
      compare_next($sformatf("v%0d", i));
    end

    // Hand-written: bounded wait for first word from requester 3 after reset.
    @(negedge clk);
    reset = 1'b0;
    req   = 4'b1000;
    din   = {16'h5A5A, 16'h1111, 16'h2222, 16'h3333};
    e.gnt = 4'b1000; e.bus = 16'h5A5A; e.vld = 1'b1;
    sb.push_back(e);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!bus_valid && lat < 6);
    check("lat3.cycles", 16'(lat), 16'd2);
    compare_next("lat3");

    @(negedge clk);
    req = 4'b0000;
    e.gnt = 4'b0000; e.bus = 16'h5A5A; e.vld = 1'b0;
    sb.push_back(e);
    @(posedge clk);
    #1;
    compare_next("lat3_rel");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
